// File: rtl/mux8_scan_ctrl_if.sv
// rtl/mux8_scan_ctrl_if.sv - handshake and select bundle between scan controller and its driver
interface mux8_scan_ctrl_if;
  logic       start;
  logic       stall;
  logic [7:0] data_in;
  logic [2:0] sel;
  logic       bit_out;
  logic       valid;
  logic       busy;
  logic       done;

  modport master (
    output start, stall, data_in,
    input  sel, bit_out, valid, busy, done
  );

  modport slave (
    input  start, stall, data_in,
    output sel, bit_out, valid, busy, done
  );
endinterface

// File: rtl/mux8_scan_ctrl.sv
// rtl/mux8_scan_ctrl.sv - steps the mux8_1 select 0..7 over a captured word and serialises it on bit_out
module mux8_scan_ctrl #(
  parameter int STEP_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  mux8_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateType;

  localparam logic [7:0] LAST_STEP = 8'(STEP_CYCLES - 1);

  stateType   state, nextState;
  logic [7:0] dataReg;
  logic [7:0] stepCnt;
  logic       stepEnd;
  logic       loadReq;
  logic       validNext, busyNext, doneNext;

  assign stepEnd = (stepCnt == LAST_STEP);
  // A start seen in DONE reloads directly, giving back-to-back scans with no IDLE gap.
  assign loadReq = bus.start && (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      state     <= nextState;
      bus.valid <= validNext;
      bus.busy  <= busyNext;
      bus.done  <= doneNext;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.start) nextState = RUN;
      RUN:     if (!bus.stall && stepEnd && (bus.sel == 3'd7)) nextState = DONE;
      DONE:    nextState = bus.start ? RUN : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Status flags are decoded from the upcoming state so they leave flops aligned with it.
  always_comb begin
    validNext = (nextState == RUN);
    busyNext  = (nextState != IDLE);
    doneNext  = (nextState == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataReg <= 8'd0;
      stepCnt <= 8'd0;
      bus.sel <= 3'd0;
    end else if (loadReq) begin
      dataReg <= bus.data_in;
      stepCnt <= 8'd0;
      bus.sel <= 3'd0;
    end else if ((state == RUN) && !bus.stall) begin
      if (!stepEnd) begin
        stepCnt <= stepCnt + 8'd1;
      end else begin
        stepCnt <= 8'd0;
        bus.sel <= (bus.sel == 3'd7) ? 3'd0 : bus.sel + 3'd1;
      end
    end
  end

  assign bus.bit_out = bus.valid ? dataReg[bus.sel] : 1'b0;

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// tb/tb_mux8_scan_ctrl.sv - directed self-checking bench for mux8_scan_ctrl
module tb_mux8_scan_ctrl;

  logic clk;
  logic rst_n;
  int   checkCnt = 0;
  int   errCnt   = 0;

  mux8_scan_ctrl_if ifA ();
  mux8_scan_ctrl_if ifB ();

  mux8_scan_ctrl #(.STEP_CYCLES(1)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  mux8_scan_ctrl #(.STEP_CYCLES(3)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

  always #5 clk = ~clk;

  localparam logic [6:0] DONE_OUT = 7'b000_0_0_1_1;
  localparam logic [6:0] IDLE_OUT = 7'b000_0_0_0_0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {sel, bit_out, valid, busy, done}
  function automatic logic [6:0] obsA();
    return {ifA.sel, ifA.bit_out, ifA.valid, ifA.busy, ifA.done};
  endfunction

  function automatic logic [6:0] obsB();
    return {ifB.sel, ifB.bit_out, ifB.valid, ifB.busy, ifB.done};
  endfunction

  function automatic logic [6:0] runOut(input int s, input int b);
    return {3'(s), 1'(b), 1'b1, 1'b1, 1'b0};
  endfunction

  int eb[8];
  int stallSel[10];
  int stallBit[10];

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    ifA.start = 1'b0; ifA.stall = 1'b0; ifA.data_in = 8'h00;
    ifB.start = 1'b0; ifB.stall = 1'b0; ifB.data_in = 8'h00;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifA.start = 1'($urandom); ifA.stall = 1'($urandom); ifA.data_in = 8'($urandom);
      ifB.start = 1'($urandom); ifB.stall = 1'($urandom); ifB.data_in = 8'($urandom);
      checkVal($sformatf("rstA%0d", i), obsA(), IDLE_OUT);
      checkVal($sformatf("rstB%0d", i), obsB(), IDLE_OUT);
    end
    @(negedge clk);
    ifA.start = 1'b0; ifA.stall = 1'b0;
    ifB.start = 1'b0; ifB.stall = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("postRstA", obsA(), IDLE_OUT);
    checkVal("postRstB", obsB(), IDLE_OUT);

    // basic scan, 8'h96
    eb = '{0, 1, 1, 0, 1, 0, 0, 1};
    ifA.data_in = 8'h96; ifA.start = 1'b1;
    @(negedge clk);
    ifA.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checkVal($sformatf("basic%0d", k), obsA(), runOut(k, eb[k]));
      @(negedge clk);
    end
    checkVal("basicDone", obsA(), DONE_OUT);
    @(negedge clk);
    checkVal("basicIdle", obsA(), IDLE_OUT);

    // three-cycle steps, 8'hA5
    eb = '{1, 0, 1, 0, 0, 1, 0, 1};
    ifB.data_in = 8'hA5; ifB.start = 1'b1;
    @(negedge clk);
    ifB.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 3; r++) begin
        checkVal($sformatf("step%0d_%0d", k, r), obsB(), runOut(k, eb[k]));
        @(negedge clk);
      end
    end
    checkVal("stepDone", obsB(), DONE_OUT);
    @(negedge clk);
    checkVal("stepIdle", obsB(), IDLE_OUT);

    // stall two cycles at sel=3; stall together with start in IDLE must still start
    stallSel = '{0, 1, 2, 3, 3, 3, 4, 5, 6, 7};
    stallBit = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    ifA.data_in = 8'h0F; ifA.start = 1'b1; ifA.stall = 1'b1;
    @(negedge clk);
    ifA.start = 1'b0; ifA.stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkVal($sformatf("stall%0d", i), obsA(), runOut(stallSel[i], stallBit[i]));
      ifA.stall = (i == 3 || i == 4);
      @(negedge clk);
    end
    ifA.stall = 1'b0;
    checkVal("stallDone", obsA(), DONE_OUT);
    @(negedge clk);
    checkVal("stallIdle", obsA(), IDLE_OUT);

    // start in RUN ignored, then back-to-back from DONE
    eb = '{0, 0, 1, 1, 1, 1, 0, 0};
    ifA.data_in = 8'h3C; ifA.start = 1'b1;
    @(negedge clk);
    ifA.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checkVal($sformatf("ign%0d", k), obsA(), runOut(k, eb[k]));
      if (k == 2) begin
        ifA.start = 1'b1; ifA.data_in = 8'h00;
      end else begin
        ifA.start = 1'b0;
      end
      @(negedge clk);
    end
    checkVal("ignDone", obsA(), DONE_OUT);
    ifA.start = 1'b1; ifA.data_in = 8'hFF;
    @(negedge clk);
    ifA.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checkVal($sformatf("b2b%0d", k), obsA(), runOut(k, 1));
      @(negedge clk);
    end
    checkVal("b2bDone", obsA(), DONE_OUT);
    @(negedge clk);
    checkVal("b2bIdle", obsA(), IDLE_OUT);

    // data_in churns after capture
    eb = '{0, 1, 0, 1, 1, 0, 1, 0};
    ifA.data_in = 8'h5A; ifA.start = 1'b1;
    @(negedge clk);
    ifA.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ifA.data_in = 8'($urandom);
      checkVal($sformatf("cap%0d", k), obsA(), runOut(k, eb[k]));
      @(negedge clk);
    end
    checkVal("capDone", obsA(), DONE_OUT);
    @(negedge clk);
    checkVal("capIdle", obsA(), IDLE_OUT);

    // asynchronous reset at sel=4
    ifA.data_in = 8'hFF; ifA.start = 1'b1;
    @(negedge clk);
    ifA.start = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    checkVal("preRst", obsA(), runOut(4, 1));
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("asyncRst", obsA(), IDLE_OUT);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("relIdle0", obsA(), IDLE_OUT);
    @(negedge clk);
    checkVal("relIdle1", obsA(), IDLE_OUT);

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
